// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax block and its downstream argmax classifier.
// Holds state encodings, binary32 constants and the ordering-key helpers.
package softmax_pkg;

  localparam int DATALENGTH_DEF = 32;
  localparam int INPUTMAX_DEF   = 2;

  localparam logic [DATALENGTH_DEF-1:0] FP_QNAN      = 32'h7FC0_0000;
  localparam logic [DATALENGTH_DEF-1:0] FP_SIGN_MASK = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RESULT  = 2'd2
  } state_e;

  // Maps a binary32 pattern onto an unsigned key that sorts as the float does.
  function automatic logic [DATALENGTH_DEF-1:0] fp_key(input logic [DATALENGTH_DEF-1:0] x);
    return x[DATALENGTH_DEF-1] ? ~x : (x ^ FP_SIGN_MASK);
  endfunction

  function automatic logic fp_is_nan(input logic [DATALENGTH_DEF-1:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction

endpackage

// File: rtl/fp_order_cmp.sv
// Combinational binary32 comparator over the total order
// -inf < negatives < -0 < +0 < positives < +inf, with a NaN detect on a.
module fp_order_cmp
  import softmax_pkg::*;
(
  input  logic [DATALENGTH_DEF-1:0] a,
  input  logic [DATALENGTH_DEF-1:0] b,
  output logic                      a_gt_b,
  output logic                      a_nan
);

  always_comb begin
    a_gt_b = fp_key(a) > fp_key(b);
    a_nan  = fp_is_nan(a);
  end

endmodule

// File: rtl/softmax_argmax.sv
// Streaming argmax over a softmax output vector: reports index/value of the maximum.
// Define SOFTMAX_ARGMAX_TOP2_EN to also track the runner-up (Index2/MaxValue2).
module softmax_argmax
  import softmax_pkg::*;
#(
  parameter int DATALENGTH = DATALENGTH_DEF,
  parameter int INPUTMAX   = INPUTMAX_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [INPUTMAX:0]     N,
  input  logic                  Valid,
  input  logic [DATALENGTH-1:0] Datain,
  output logic                  Busy,
  output logic                  Done,
  output logic [INPUTMAX-1:0]   Index,
  output logic [DATALENGTH-1:0] MaxValue,
  output logic                  NanFlag
`ifdef SOFTMAX_ARGMAX_TOP2_EN
  ,
  output logic [INPUTMAX-1:0]   Index2,
  output logic [DATALENGTH-1:0] MaxValue2
`endif
);

  localparam logic [INPUTMAX-1:0] CNT_ONE = INPUTMAX'(1);

  state_e                state_q, state_d;
  logic [INPUTMAX-1:0]   last_q, last_d;
  logic [INPUTMAX-1:0]   cnt_q, cnt_d;
  logic [INPUTMAX-1:0]   best_idx_q, best_idx_d;
  logic [DATALENGTH-1:0] best_val_q, best_val_d;
  logic                  have_best_q, have_best_d;
  logic                  nan_seen_q, nan_seen_d;
  logic [INPUTMAX-1:0]   idx_out_q, idx_out_d;
  logic [DATALENGTH-1:0] max_out_q, max_out_d;
  logic                  nan_out_q, nan_out_d;

  logic start_vec, accept, last_acc, take;
  logic in_gt_best, in_nan;

  fp_order_cmp u_cmp_best (
    .a      (Datain),
    .b      (best_val_q),
    .a_gt_b (in_gt_best),
    .a_nan  (in_nan)
  );

  always_comb begin
    start_vec = (state_q == ST_IDLE) && Start;
    accept    = (state_q == ST_COLLECT) && Valid;
    last_acc  = accept && (cnt_q == last_q);
    take      = accept && !in_nan && (!have_best_q || in_gt_best);
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    best_idx_d  = best_idx_q;
    best_val_d  = best_val_q;
    have_best_d = have_best_q;
    nan_seen_d  = nan_seen_q;
    idx_out_d   = idx_out_q;
    max_out_d   = max_out_q;
    nan_out_d   = nan_out_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          // Lengths beyond the buffer depth saturate to the deepest index.
          last_d      = N[INPUTMAX] ? {INPUTMAX{1'b1}} : N[INPUTMAX-1:0];
          cnt_d       = '0;
          nan_seen_d  = 1'b0;
          best_val_d  = FP_QNAN;
          best_idx_d  = '0;
          have_best_d = 1'b0;
          state_d     = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_ONE;
          if (in_nan) nan_seen_d = 1'b1;
          if (take) begin
            best_val_d  = Datain;
            best_idx_d  = cnt_q;
            have_best_d = 1'b1;
          end
          if (last_acc) begin
            idx_out_d = best_idx_d;
            max_out_d = best_val_d;
            nan_out_d = nan_seen_d;
            state_d   = ST_RESULT;
          end
        end
      end
      ST_RESULT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      last_q      <= '0;
      cnt_q       <= '0;
      best_idx_q  <= '0;
      best_val_q  <= FP_QNAN;
      have_best_q <= 1'b0;
      nan_seen_q  <= 1'b0;
      idx_out_q   <= '0;
      max_out_q   <= '0;
      nan_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      best_idx_q  <= best_idx_d;
      best_val_q  <= best_val_d;
      have_best_q <= have_best_d;
      nan_seen_q  <= nan_seen_d;
      idx_out_q   <= idx_out_d;
      max_out_q   <= max_out_d;
      nan_out_q   <= nan_out_d;
    end
  end

  assign Busy     = (state_q == ST_COLLECT);
  assign Done     = (state_q == ST_RESULT);
  assign Index    = idx_out_q;
  assign MaxValue = max_out_q;
  assign NanFlag  = nan_out_q;

`ifdef SOFTMAX_ARGMAX_TOP2_EN
  logic [INPUTMAX-1:0]   sec_idx_q, sec_idx_d;
  logic [DATALENGTH-1:0] sec_val_q, sec_val_d;
  logic                  have_sec_q, have_sec_d;
  logic [INPUTMAX-1:0]   idx2_out_q, idx2_out_d;
  logic [DATALENGTH-1:0] max2_out_q, max2_out_d;
  logic                  in_gt_sec, in_nan_sec;

  fp_order_cmp u_cmp_sec (
    .a      (Datain),
    .b      (sec_val_q),
    .a_gt_b (in_gt_sec),
    .a_nan  (in_nan_sec)
  );

  always_comb begin
    sec_idx_d  = sec_idx_q;
    sec_val_d  = sec_val_q;
    have_sec_d = have_sec_q;
    idx2_out_d = idx2_out_q;
    max2_out_d = max2_out_q;
    if (start_vec) begin
      sec_idx_d  = '0;
      sec_val_d  = FP_QNAN;
      have_sec_d = 1'b0;
    end else if (accept) begin
      // A displaced best always becomes the runner-up; otherwise strict-greater wins.
      if (take) begin
        if (have_best_q) begin
          sec_idx_d  = best_idx_q;
          sec_val_d  = best_val_q;
          have_sec_d = 1'b1;
        end
      end else if (!in_nan_sec && (!have_sec_q || in_gt_sec)) begin
        sec_idx_d  = cnt_q;
        sec_val_d  = Datain;
        have_sec_d = 1'b1;
      end
      if (last_acc) begin
        idx2_out_d = sec_idx_d;
        max2_out_d = sec_val_d;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sec_idx_q  <= '0;
      sec_val_q  <= FP_QNAN;
      have_sec_q <= 1'b0;
      idx2_out_q <= '0;
      max2_out_q <= '0;
    end else begin
      sec_idx_q  <= sec_idx_d;
      sec_val_q  <= sec_val_d;
      have_sec_q <= have_sec_d;
      idx2_out_q <= idx2_out_d;
      max2_out_q <= max2_out_d;
    end
  end

  assign Index2    = idx2_out_q;
  assign MaxValue2 = max2_out_q;
`endif

endmodule

// File: tb/tb_softmax_argmax.sv
// Directed self-checking bench for softmax_argmax with hand-computed expectations.
// Runner-up checks are compiled in when SOFTMAX_ARGMAX_TOP2_EN is defined.
module tb_softmax_argmax;
  import softmax_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  N     = '0;
  logic        Valid = 1'b0;
  logic [31:0] Datain = '0;
  logic        Busy, Done, NanFlag;
  logic [1:0]  Index;
  logic [31:0] MaxValue;
`ifdef SOFTMAX_ARGMAX_TOP2_EN
  logic [1:0]  Index2;
  logic [31:0] MaxValue2;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] vec [4];

  softmax_argmax dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .N        (N),
    .Valid    (Valid),
    .Datain   (Datain),
    .Busy     (Busy),
    .Done     (Done),
    .Index    (Index),
    .MaxValue (MaxValue),
    .NanFlag  (NanFlag)
`ifdef SOFTMAX_ARGMAX_TOP2_EN
    ,
    .Index2   (Index2),
    .MaxValue2(MaxValue2)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Runs one vector of cnt back-to-back elements from vec[], leaves the bench in the Done cycle.
  task automatic run_vec(input string tag, input logic [2:0] n, input int cnt);
    @(negedge Clock);
    Start = 1'b1;
    N     = n;
    @(negedge Clock);
    Start = 1'b0;
    chk({tag, "_busy"}, 32'(Busy), 32'd1);
    for (int i = 0; i < cnt; i++) begin
      Valid  = 1'b1;
      Datain = vec[i];
      @(negedge Clock);
      if (i < cnt - 1) chk({tag, "_early_done"}, 32'(Done), 32'd0);
    end
    Valid = 1'b0;
    chk({tag, "_done"}, 32'(Done), 32'd1);
  endtask

  task automatic chk_res(input string tag, input logic [1:0] idx, input logic [31:0] mv,
                         input logic nf, input logic [1:0] idx2, input logic [31:0] mv2);
    chk({tag, "_index"}, 32'(Index), 32'(idx));
    chk({tag, "_max"}, MaxValue, mv);
    chk({tag, "_nan"}, 32'(NanFlag), 32'(nf));
`ifdef SOFTMAX_ARGMAX_TOP2_EN
    chk({tag, "_index2"}, 32'(Index2), 32'(idx2));
    chk({tag, "_max2"}, MaxValue2, mv2);
`else
    if (idx2 != idx2 || mv2 != mv2) chk({tag, "_unused"}, 32'd0, 32'd1);
`endif
    @(negedge Clock);
    chk({tag, "_done_once"}, 32'(Done), 32'd0);
    chk({tag, "_idle"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_index", 32'(Index), 32'd0);
    chk("rst_max", MaxValue, 32'd0);
    chk("rst_nan", 32'(NanFlag), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;

    vec = '{32'h3E000000, 32'h3F000000, 32'h3E800000, 32'h3E000000};
    run_vec("basic", 3'd3, 4);
    chk_res("basic", 2'd1, 32'h3F000000, 1'b0, 2'd2, 32'h3E800000);

    vec = '{32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000};
    run_vec("tie", 3'd3, 4);
    chk_res("tie", 2'd0, 32'h3F000000, 1'b0, 2'd1, 32'h3F000000);

    vec = '{32'h80000000, 32'h00000000, 32'hBF800000, 32'hC0000000};
    run_vec("zero", 3'd3, 4);
    chk_res("zero", 2'd1, 32'h00000000, 1'b0, 2'd0, 32'h80000000);

    vec = '{32'h7FC00001, 32'h3F800000, 32'h7F800000, 32'h3F000000};
    run_vec("nan", 3'd3, 4);
    chk_res("nan", 2'd2, 32'h7F800000, 1'b1, 2'd1, 32'h3F800000);

    vec = '{32'h7FC00001, 32'hFFC00000, 32'h7F800001, 32'hFF812345};
    run_vec("allnan", 3'd3, 4);
    chk_res("allnan", 2'd0, 32'h7FC00000, 1'b1, 2'd0, 32'h7FC00000);

    // Stalled, clamped vector with a stray Start in the middle.
    @(negedge Clock);
    Start = 1'b1;
    N     = 3'd7;
    @(negedge Clock);
    Start = 1'b0;
    begin
      logic [6:0]  vpat;
      logic [31:0] vals [4];
      int          k;
      int          dones;
      vpat  = 7'b1001101;
      vals  = '{32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h40000000};
      k     = 0;
      dones = 0;
      for (int i = 0; i < 7; i++) begin
        Valid  = vpat[6-i];
        Datain = vpat[6-i] ? vals[k] : 32'hFFFFFFFF;
        if (vpat[6-i]) k++;
        Start = (i == 2);
        N     = (i == 2) ? 3'd0 : 3'd7;
        @(negedge Clock);
        if (Done) dones++;
      end
      Valid = 1'b0;
      Start = 1'b0;
      chk("stall_no_early_done", 32'(dones), 32'd1);
      chk("stall_done_last", 32'(Done), 32'd1);
    end
    chk_res("stall", 2'd3, 32'h40000000, 1'b0, 2'd0, 32'h3F800000);

    // Reset in the middle of a vector aborts it.
    @(negedge Clock);
    Start = 1'b1;
    N     = 3'd3;
    @(negedge Clock);
    Start  = 1'b0;
    Valid  = 1'b1;
    Datain = 32'h3F800000;
    @(negedge Clock);
    Datain = 32'h3F000000;
    @(negedge Clock);
    Valid = 1'b0;
    Reset = 1'b0;
    #1;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_index", 32'(Index), 32'd0);
    chk("abort_max", MaxValue, 32'd0);
    chk("abort_nan", 32'(NanFlag), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    begin
      int dones;
      dones = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge Clock);
        if (Done) dones++;
      end
      chk("abort_no_done", 32'(dones), 32'd0);
    end

    vec = '{32'h3F800000, 32'h0, 32'h0, 32'h0};
    run_vec("len1", 3'd0, 1);
    chk_res("len1", 2'd0, 32'h3F800000, 1'b0, 2'd0, 32'h7FC00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
